// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy over the dmemreq/dmemresp port group.
// Optional running checksum of read words: define MEM_COPY_CHECKSUM_EN.
module mem_copy_engine #(
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum,
  output logic             dmemreq_val,
  output logic             dmemreq_type,
  output logic [31:0]      dmemreq_addr,
  output logic [31:0]      dmemreq_wdata,
  input  logic [31:0]      dmemresp_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      src_r;
  logic [31:0]      dst_r;
  logic [31:0]      data_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] idx;
  logic [31:0]      idx_off;
  logic             last;
  logic             accept;

  assign idx_off = STEP * 32'(idx);
  assign last    = (idx == len_r - LEN_W'(1));
  assign accept  = (state == IDLE) && start;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and registered-state output decode
  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    dmemreq_val   = 1'b0;
    dmemreq_type  = 1'b0;
    dmemreq_addr  = 32'h0;
    dmemreq_wdata = 32'h0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = (len == '0) ? DONE : READ;
      end
      READ: begin
        busy         = 1'b1;
        dmemreq_val  = 1'b1;
        dmemreq_addr = src_r + idx_off;
        state_nxt    = WRITE;
      end
      WRITE: begin
        busy          = 1'b1;
        dmemreq_val   = 1'b1;
        dmemreq_type  = 1'b1;
        dmemreq_addr  = dst_r + idx_off;
        dmemreq_wdata = data_r;
        state_nxt     = last ? DONE : READ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch, word index and read data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_r  <= 32'h0;
      dst_r  <= 32'h0;
      len_r  <= '0;
      idx    <= '0;
      data_r <= 32'h0;
    end else if (accept) begin
      src_r <= src;
      dst_r <= dst;
      len_r <= len;
      idx   <= '0;
    end else if (state == READ) begin
      data_r <= dmemresp_rdata;
    end else if (state == WRITE && !last) begin
      idx <= idx + LEN_W'(1);
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] csum_r;

  // running sum of read words, held from DONE until next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                csum_r <= 32'h0;
    else if (accept)        csum_r <= 32'h0;
    else if (state == READ) csum_r <= csum_r + dmemresp_rdata;
  end

  assign checksum = csum_r;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Data-memory request initiator that copies a block of 32-bit words from a source address range to a destination address range. It drives the same dmemreq/dmemresp port group that a test memory responds to. That memory reads combinationally and writes at the rising clock edge. The engine sits beside the TinyRV1 processor in system-level benches and serves as a standalone memory-traffic generator for exercising that memory interface.

## Interface

Parameters:
- LEN_W, 16: width of the word-count input and of the internal word counter.
- ADDR_STEP, 4: byte increment between consecutive word addresses.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a copy; sampled only in IDLE.
- src  input  32  source base byte address; captured when start is accepted.
- dst  input  32  destination base byte address; captured when start is accepted.
- len  input  LEN_W  number of words to copy; captured when start is accepted.
- busy  output  1  high in READ and WRITE.
- done  output  1  one-cycle completion pulse.
- checksum  output  32  running sum of words read (see Configuration).
- dmemreq_val  output  1  request valid.
- dmemreq_type  output  1  0 = read, 1 = write.
- dmemreq_addr  output  32  request byte address.
- dmemreq_wdata  output  32  write data.
- dmemresp_rdata  input  32  read data; combinational response in the same cycle as the read request.

## Operation

- The FSM has four states: IDLE, READ, WRITE, DONE.
- IDLE:
  - If start=1 at the clock edge, latch src, dst and len, and clear the word index i and the checksum.
  - If len≠0, go to READ.
  - If len=0, go directly to DONE. No memory request is ever issued.
- READ:
  - Drive dmemreq_val=1, dmemreq_type=0, dmemreq_addr=src+ADDR_STEP·i.
  - At the clock edge, capture dmemresp_rdata into the data register and go to WRITE.
- WRITE:
  - Drive dmemreq_val=1, dmemreq_type=1, dmemreq_addr=dst+ADDR_STEP·i, dmemreq_wdata=data register.
  - At the clock edge: if i==len−1, go to DONE; otherwise i←i+1 and go to READ.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- start is ignored in READ, WRITE and DONE. There is no queueing.
- Address arithmetic is 32-bit modulo 2^32, so addresses wrap past 0xFFFFFFFC silently.
- Overlapping ranges are copied forward, word by word, with no hazard handling. For example, dst=src+4 replicates word 0 across the whole range.
- Output values outside READ/WRITE:
  - dmemreq_val=0.
  - dmemreq_type=0, dmemreq_addr=0 and dmemreq_wdata=0 (never X).
- dmemresp_rdata is sampled only in READ. X on this input in any other state must not propagate.

## Timing

- Reset (asynchronous) forces, immediately:
  - state=IDLE.
  - busy=0, done=0, dmemreq_val=0, checksum=0.
  - Address and data registers = 0.
- Reset during READ or WRITE aborts the copy. Any write already committed at an earlier edge stays in memory. No further requests are issued.
- Start accepted at edge k with len=N≥1:
  - READ occupies cycles k+1, k+3, …, k+2N−1.
  - WRITE occupies cycles k+2, k+4, …, k+2N.
  - done=1 in cycle k+2N+1.
  - The earliest next start is accepted at the edge ending cycle k+2N+2.
- len=0: done=1 in cycle k+1.
- Throughput is one word per 2 cycles. Read-to-write latency is 1 cycle.
- All outputs are registered state decodes and do not depend combinationally on start, src, dst or len.

## Configuration

- MEM_COPY_CHECKSUM_EN defined:
  - In READ, checksum ← checksum + dmemresp_rdata (mod 2^32).
  - checksum is cleared on start accept and is held stable from DONE until the next accepted start.
- MEM_COPY_CHECKSUM_EN undefined:
  - The checksum port remains, tied to 32'h0.
  - No adder is synthesized.

## Test plan

- Basic copy:
  - Stimulus: memory words at 0x100–0x10C = 0x11, 0x22, 0x33, 0x44; start with src=0x100, dst=0x200, len=4.
  - Required: 0x200–0x20C match the source; busy high for 8 cycles; done pulses in cycle 9 after start; checksum=0xAA with the macro defined, 0 without it.
- Zero length:
  - Stimulus: start with len=0.
  - Required: done the next cycle; dmemreq_val never asserts.
- Start while busy:
  - Stimulus: second start with different src/dst/len while the first copy (len=3) is running.
  - Required: second start ignored; exactly 6 requests issued, in the R,W,R,W,R,W pattern with the correct addresses.
- Reset mid-copy:
  - Stimulus: assert rst asynchronously during the second WRITE of a len=4 copy.
  - Required: all outputs drop to reset values without waiting for a clock edge; only dst word 0 is written; a new start after reset completes correctly.
- Address wrap and overlap:
  - Stimulus A: src=0xFFFFFFFC, len=2.
  - Required A: second read address is 0x00000000.
  - Stimulus B: src=0x100, dst=0x104, len=3, source data 0xA, 0xB, 0xC.
  - Required B: 0x104–0x10C all hold 0xA.
